mux8_scan_seq: RTL and testbench

//  Upstream sequencer for the 8:1 bit-select mux. Accepts an 8-bit word on a

---
 rtl/mux8_pkg.sv | 28 ++
 rtl/mux8_sel_cnt.sv | 37 +++
 rtl/mux8_scan_seq.sv | 150 +++++++++++++++
 tb/tb_mux8_scan_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux8_pkg.sv
// Shared constants, state encoding and select-range helpers for the 8:1 mux sequencer.
package mux8_pkg;

  localparam int unsigned W_WORD = 8;
  localparam int unsigned W_SEL  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_PAR  = 2'd2
  } state_t;

  // First select index of a scan.
  function automatic logic [W_SEL-1:0] sel_first(input bit msb_first);
    return msb_first ? W_SEL'(W_WORD - 1) : W_SEL'(0);
  endfunction

  // Last select index of a scan.
  function automatic logic [W_SEL-1:0] sel_last(input bit msb_first);
    return msb_first ? W_SEL'(0) : W_SEL'(W_WORD - 1);
  endfunction

  // Index one step before the last; lets the top register OUT_LAST ahead of time.
  function automatic logic [W_SEL-1:0] sel_pre_last(input bit msb_first);
    return msb_first ? W_SEL'(1) : W_SEL'(W_WORD - 2);
  endfunction

endpackage

// File: rtl/mux8_sel_cnt.sv
// 3-bit select counter: load to the scan start, step up or down, flag the end of the scan.
module mux8_sel_cnt
  import mux8_pkg::*;
#(
  parameter bit DOWN = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_load,
  input  logic             i_en,
  output logic [W_SEL-1:0] o_cnt,
  output logic             o_tc_c,
  output logic             o_pre_tc_c
);

  localparam logic [W_SEL-1:0] C_START = sel_first(DOWN);
  localparam logic [W_SEL-1:0] C_END   = sel_last(DOWN);
  localparam logic [W_SEL-1:0] C_PRE   = sel_pre_last(DOWN);

  logic [W_SEL-1:0] r_cnt;

  // Counter register; load has priority over stepping.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= C_START;
    end else if (i_load) begin
      r_cnt <= C_START;
    end else if (i_en) begin
      r_cnt <= DOWN ? (r_cnt - W_SEL'(1)) : (r_cnt + W_SEL'(1));
    end
  end

  assign o_cnt      = r_cnt;
  assign o_tc_c     = (r_cnt == C_END);
  assign o_pre_tc_c = (r_cnt == C_PRE);

endmodule

// File: rtl/mux8_scan_seq.sv
// Sequencer that turns an external 8:1 bit-select mux into an 8-beat parallel-to-serial path.
// Optional trailing even-parity beat: define MUX8_SCAN_PARITY_EN.
module mux8_scan_seq
  import mux8_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [W_WORD-1:0] D,
  output logic [W_WORD-1:0] WORD,
  output logic [W_SEL-1:0]  SEL,
  input  logic              FBIT,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              OUT_BIT,
  output logic              OUT_LAST
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [W_WORD-1:0] r_word;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_out_last;
  logic              w_last_nxt;
  logic              w_word_ld;
  logic              w_cnt_ld;
  logic              w_cnt_en;
  logic              w_xfer;
  logic              w_tc;
  logic              w_pre_tc;
  logic [W_SEL-1:0]  w_sel;

  assign w_xfer = r_out_valid & OUT_READY;

  mux8_sel_cnt #(
    .DOWN (MSB_FIRST)
  ) u_sel_cnt (
    .CLK        (CLK),
    .RST        (RST),
    .i_load     (w_cnt_ld),
    .i_en       (w_cnt_en),
    .o_cnt      (w_sel),
    .o_tc_c     (w_tc),
    .o_pre_tc_c (w_pre_tc)
  );

`ifdef MUX8_SCAN_PARITY_EN
  logic r_acc;
  logic w_acc_clr;
`endif

  // State and registered handshake/flag outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_word      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      if (w_word_ld) r_word <= D;
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_out_valid <= (w_state_nxt != ST_IDLE);
      r_out_last  <= w_last_nxt;
    end
  end

  // Next-state and control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_word_ld   = 1'b0;
    w_cnt_ld    = 1'b0;
    w_cnt_en    = 1'b0;
    w_last_nxt  = r_out_last;
`ifdef MUX8_SCAN_PARITY_EN
    w_acc_clr   = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (IN_VALID && r_in_ready) begin
          w_state_nxt = ST_SCAN;
          w_word_ld   = 1'b1;
          w_cnt_ld    = 1'b1;
          w_last_nxt  = 1'b0;
        end
      end
      ST_SCAN: begin
        if (w_xfer) begin
          if (w_tc) begin
            w_cnt_ld = 1'b1;
`ifdef MUX8_SCAN_PARITY_EN
            w_state_nxt = ST_PAR;
            w_last_nxt  = 1'b1;
`else
            w_state_nxt = ST_IDLE;
            w_last_nxt  = 1'b0;
`endif
          end else begin
            w_cnt_en = 1'b1;
`ifdef MUX8_SCAN_PARITY_EN
            w_last_nxt = 1'b0;
`else
            w_last_nxt = w_pre_tc;
`endif
          end
        end
      end
`ifdef MUX8_SCAN_PARITY_EN
      ST_PAR: begin
        if (w_xfer) begin
          w_state_nxt = ST_IDLE;
          w_acc_clr   = 1'b1;
          w_last_nxt  = 1'b0;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
        w_last_nxt  = 1'b0;
      end
    endcase
  end

`ifdef MUX8_SCAN_PARITY_EN
  // Running XOR of transferred data bits; cleared once the parity beat leaves.
  always_ff @(posedge CLK) begin
    if (RST || w_acc_clr) begin
      r_acc <= 1'b0;
    end else if (w_xfer && (r_state == ST_SCAN)) begin
      r_acc <= r_acc ^ FBIT;
    end
  end

  assign OUT_BIT = (r_state == ST_PAR) ? r_acc : FBIT;
`else
  assign OUT_BIT = FBIT;
`endif

  assign IN_READY  = r_in_ready;
  assign OUT_VALID = r_out_valid;
  assign OUT_LAST  = r_out_last;
  assign WORD      = r_word;
  assign SEL       = w_sel;

endmodule

// File: tb/tb_mux8_scan_seq.sv
// Bench: LSB-first and MSB-first sequencers in lockstep, each feeding its own 8:1 mux,
// checked against a queue of expected beats.
module tb_mux8_scan_seq;

`ifdef MUX8_SCAN_PARITY_EN
  localparam int BEATS = 9;
`else
  localparam int BEATS = 8;
`endif

  typedef struct {
    logic       b;
    logic       last;
    logic [2:0] sel;
    logic [7:0] word;
    bit         par;
  } beat_t;

  typedef struct {
    logic [7:0] d;
    logic [3:0] pat;
    logic       exp_par;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RST;
  logic       IN_VALID;
  logic       OUT_READY;
  logic [7:0] D;

  logic       in_ready [2];
  logic       out_valid[2];
  logic       out_bit  [2];
  logic       out_last [2];
  logic       fbit     [2];
  logic [7:0] word     [2];
  logic [2:0] sel      [2];

  beat_t      q0[$];
  beat_t      q1[$];
  logic [7:0] rec  [2];
  int         beats[2];
  int         total = 0;
  int         bad   = 0;
  int         acc_cnt = 0;

  always #5 CLK = ~CLK;

  assign fbit[0] = word[0][sel[0]];
  assign fbit[1] = word[1][sel[1]];

  mux8_scan_seq #(.MSB_FIRST(1'b0)) u_lsb (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(in_ready[0]), .D(D),
    .WORD(word[0]), .SEL(sel[0]), .FBIT(fbit[0]), .OUT_VALID(out_valid[0]),
    .OUT_READY(OUT_READY), .OUT_BIT(out_bit[0]), .OUT_LAST(out_last[0])
  );

  mux8_scan_seq #(.MSB_FIRST(1'b1)) u_msb (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(in_ready[1]), .D(D),
    .WORD(word[1]), .SEL(sel[1]), .FBIT(fbit[1]), .OUT_VALID(out_valid[1]),
    .OUT_READY(OUT_READY), .OUT_BIT(out_bit[1]), .OUT_LAST(out_last[1])
  );

  task automatic chk(input string nm, input int u, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d act=%0h exp=%0h", nm, u, act, exp);
    end
  endtask

  // Expected beats for one accepted word, for both scan orders.
  task automatic push_word(input logic [7:0] w);
    beat_t b;
    for (int k = 0; k < 8; k++) begin
      b.word = w;
      b.par  = 1'b0;
`ifdef MUX8_SCAN_PARITY_EN
      b.last = 1'b0;
`else
      b.last = (k == 7);
`endif
      b.sel = 3'(k);
      b.b   = w[k];
      q0.push_back(b);
      b.sel = 3'(7 - k);
      b.b   = w[7 - k];
      q1.push_back(b);
    end
`ifdef MUX8_SCAN_PARITY_EN
    b.word = w;
    b.par  = 1'b1;
    b.last = 1'b1;
    b.b    = ^w;
    b.sel  = 3'd0;
    q0.push_back(b);
    b.sel  = 3'd7;
    q1.push_back(b);
`endif
  endtask

  // One clock: drive inputs, check outputs against the model, then advance.
  task automatic cycle(input logic vin, input logic [7:0] d, input logic rdy, input logic rst);
    bit    was_empty;
    beat_t f;
    int    sz;
    IN_VALID  = vin;
    D         = d;
    OUT_READY = rdy;
    RST       = rst;
    #1;
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      was_empty = (q0.size() == 0);
      for (int u = 0; u < 2; u++) begin
        sz = (u == 0) ? q0.size() : q1.size();
        chk("in_ready", u, 8'(in_ready[u]), 8'(sz == 0));
        chk("out_valid", u, 8'(out_valid[u]), 8'(sz != 0));
        if (sz != 0) begin
          f = (u == 0) ? q0[0] : q1[0];
          chk("out_bit", u, 8'(out_bit[u]), 8'(f.b));
          chk("out_last", u, 8'(out_last[u]), 8'(f.last));
          chk("sel", u, 8'(sel[u]), 8'(f.sel));
          chk("word", u, word[u], f.word);
          if (rdy) begin
            if (u == 0) f = q0.pop_front();
            else        f = q1.pop_front();
            if (!f.par) rec[u][f.sel] = out_bit[u];
            beats[u]++;
          end
        end
      end
      if (vin && was_empty) begin
        push_word(d);
        acc_cnt++;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic check_rst();
    for (int u = 0; u < 2; u++) begin
      chk("rst_valid", u, 8'(out_valid[u]), 8'h00);
      chk("rst_last", u, 8'(out_last[u]), 8'h00);
      chk("rst_ready", u, 8'(in_ready[u]), 8'h01);
      chk("rst_word", u, word[u], 8'h00);
      chk("rst_sel", u, 8'(sel[u]), (u == 0) ? 8'h00 : 8'h07);
    end
  endtask

  task automatic drain_check(input string nm, input int budget);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
      cycle(1'b0, 8'($urandom), 1'b1, 1'b0);
      n++;
    end
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL %s drain timeout left=%0d need=0", nm, q0.size() + q1.size());
      q0.delete();
      q1.delete();
    end
  endtask

  task automatic run_word(input vec_t v);
    int n;
    beats[0] = 0;
    beats[1] = 0;
    rec[0]   = ~v.d;
    rec[1]   = ~v.d;
    cycle(1'b1, v.d, v.pat[0], 1'b0);
    n = 1;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      cycle(1'b0, 8'($urandom), v.pat[n % 4], 1'b0);
      n++;
    end
    drain_check("run_word", 50);
    for (int u = 0; u < 2; u++) begin
      chk("rx_word", u, rec[u], v.d);
      chk("rx_parity", u, 8'(^rec[u]), 8'(v.exp_par));
      chk("beat_count", u, 8'(beats[u]), 8'(BEATS));
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  vec_t vecs[7];

  initial begin
    int gap;
    int n;
    vecs[0] = '{d: 8'hA5, pat: 4'b1111, exp_par: 1'b0};
    vecs[1] = '{d: 8'h80, pat: 4'b1111, exp_par: 1'b1};
    vecs[2] = '{d: 8'h3C, pat: 4'b1001, exp_par: 1'b0};
    vecs[3] = '{d: 8'h5A, pat: 4'b0110, exp_par: 1'b0};
    vecs[4] = '{d: 8'h07, pat: 4'b1111, exp_par: 1'b1};
    vecs[5] = '{d: 8'hC3, pat: 4'b1101, exp_par: 1'b0};
    vecs[6] = '{d: 8'hE1, pat: 4'b1011, exp_par: 1'b0};

    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check_rst();

    for (int i = 0; i < 7; i++) run_word(vecs[i]);

    // IN_VALID held high across two words: second is taken in the single IDLE cycle.
    acc_cnt  = 0;
    gap      = 0;
    n        = 0;
    beats[0] = 0;
    beats[1] = 0;
    while (n < 80 && !(acc_cnt == 2 && q0.size() == 0 && q1.size() == 0)) begin
      if (acc_cnt == 1 && in_ready[0] === 1'b1) gap++;
      cycle(acc_cnt < 2, (acc_cnt == 0) ? 8'hFF : 8'h00, 1'b1, 1'b0);
      n++;
    end
    drain_check("back_to_back", 10);
    chk("b2b_words", 0, 8'(acc_cnt), 8'd2);
    chk("b2b_gap", 0, 8'(gap), 8'd1);
    chk("b2b_beats", 0, 8'(beats[0]), 8'(2 * BEATS));
    chk("b2b_rx", 0, rec[0], 8'h00);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset while beat 4 of 8'h5A is on the output.
    cycle(1'b1, 8'h5A, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre_rst_sel", 0, 8'(sel[0]), 8'd3);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    check_rst();
    run_word(vecs[5]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
